// File: rtl/sniffer_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : sniffer_rx_controller
// Purpose  : Receive sequencer for the Ethernet sniffer. Accepts one
//            Avalon-ST packet at a time, delays capture write strobes to line
//            up with the matcher/shift pipeline, generates capture-buffer
//            addresses, commits or discards each packet and keeps the four
//            saturating hit counters.
// Revision : 1.0  initial release
// ============================================================================
module sniffer_rx_controller #(
    parameter int          PIPE_LAT   = 5,
    parameter logic [31:0] ADDR_STEP  = 32'd4,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
    parameter int          MAX_WORDS  = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update_done,
    input  logic        sop,
    input  logic        eop,
    input  logic        valid,
    input  logic [5:0]  error,
    input  logic [1:0]  empty,
    input  logic        mac_match,
    input  logic        ip_match,
    input  logic        port_match,
    input  logic        url_match,
    output logic        ready,
    output logic        shift_en,
    output logic        matcher_clear,
    output logic        write_enable,
    output logic [31:0] addr_out,
    output logic [31:0] pkt_base,
    output logic [15:0] pkt_bytes,
    output logic        pkt_done,
    output logic        pkt_drop,
    output logic [31:0] mac_hits,
    output logic [31:0] ip_hits,
    output logic [31:0] port_hits,
    output logic [31:0] url_hits
);

    // Word counter saturates one past MAX_WORDS, which is enough to flag overflow.
    localparam int CNT_W = $clog2(MAX_WORDS + 2);
    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [CNT_W-1:0] C_MAX_WORDS  = CNT_W'(MAX_WORDS);
    localparam logic [DRN_W-1:0] C_DRAIN_LAST = DRN_W'(PIPE_LAT - 1);

    localparam logic [2:0] C_IDLE   = 3'd0;
    localparam logic [2:0] C_ARM    = 3'd1;
    localparam logic [2:0] C_RECV   = 3'd2;
    localparam logic [2:0] C_DRAIN  = 3'd3;
    localparam logic [2:0] C_COMMIT = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic                bad_q, bad_d;
    logic [15:0]         bytes_q, bytes_d;
    logic [DRN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         pkt_base_q, pkt_base_d;
    logic [15:0]         pkt_bytes_q, pkt_bytes_d;
    logic                pkt_done_q, pkt_done_d;
    logic                pkt_drop_q, pkt_drop_d;
    logic [31:0]         mac_hits_q, mac_hits_d;
    logic [31:0]         ip_hits_q, ip_hits_d;
    logic [31:0]         port_hits_q, port_hits_d;
    logic [31:0]         url_hits_q, url_hits_d;

    logic                w_accept;
    logic                w_err;
    logic                w_wr_in;
    logic                w_bad_now;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic [31:0]         w_addr_next;

    // Next-state, write-pipeline feed, address and counter update logic.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        bad_d         = bad_q;
        bytes_d       = bytes_q;
        drain_cnt_d   = drain_cnt_q;
        addr_d        = addr_q;
        pkt_base_d    = pkt_base_q;
        pkt_bytes_d   = pkt_bytes_q;
        pkt_done_d    = 1'b0;
        pkt_drop_d    = 1'b0;
        mac_hits_d    = mac_hits_q;
        ip_hits_d     = ip_hits_q;
        port_hits_d   = port_hits_q;
        url_hits_d    = url_hits_q;
        matcher_clear = 1'b0;
        w_wr_in       = 1'b0;
        w_bad_now     = 1'b0;

        ready     = (state_q == C_ARM) || (state_q == C_RECV);
        w_accept  = ready & valid;
        shift_en  = w_accept;
        w_err     = (error != 6'd0);
        w_cnt_inc = (word_cnt_q > C_MAX_WORDS) ? word_cnt_q : word_cnt_q + 1'b1;

        // A write consumes one slot; reaching the buffer end wraps to zero.
        w_addr_next = addr_q + ADDR_STEP;
        if (w_addr_next == ADDR_LIMIT) begin
            w_addr_next = 32'd0;
        end
        if (pipe_q[PIPE_LAT-1]) begin
            addr_d = w_addr_next;
        end

        case (state_q)
            C_IDLE: begin
                if (update_done) begin
                    matcher_clear = 1'b1;
                    state_d       = C_ARM;
                end
            end
            C_ARM: begin
                // Words arriving before a start-of-packet are discarded.
                if (w_accept && sop) begin
                    pkt_base_d  = addr_q;
                    word_cnt_d  = CNT_W'(1);
                    bad_d       = w_err;
                    w_wr_in     = !w_err;
                    drain_cnt_d = '0;
                    if (eop) begin
                        bytes_d = 16'd4 - 16'(empty);
                        state_d = C_DRAIN;
                    end else begin
                        state_d = C_RECV;
                    end
                end
            end
            C_RECV: begin
                if (w_accept) begin
                    // Once bad, no later word of the packet is written.
                    w_bad_now  = bad_q | w_err | sop | (w_cnt_inc > C_MAX_WORDS);
                    word_cnt_d = w_cnt_inc;
                    bad_d      = w_bad_now;
                    w_wr_in    = !w_bad_now;
                    if (eop) begin
                        bytes_d     = 16'({w_cnt_inc, 2'b00}) - 16'(empty);
                        drain_cnt_d = '0;
                        state_d     = C_DRAIN;
                    end
                end
            end
            C_DRAIN: begin
                // Let the final word leave the pipeline before deciding.
                if (drain_cnt_q == C_DRAIN_LAST) begin
                    state_d = C_COMMIT;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            C_COMMIT: begin
                if (!bad_q) begin
                    pkt_done_d  = 1'b1;
                    pkt_bytes_d = bytes_q;
                    if (mac_match  && (mac_hits_q  != 32'hFFFF_FFFF)) mac_hits_d  = mac_hits_q  + 32'd1;
                    if (ip_match   && (ip_hits_q   != 32'hFFFF_FFFF)) ip_hits_d   = ip_hits_q   + 32'd1;
                    if (port_match && (port_hits_q != 32'hFFFF_FFFF)) port_hits_d = port_hits_q + 32'd1;
                    if (url_match  && (url_hits_q  != 32'hFFFF_FFFF)) url_hits_d  = url_hits_q  + 32'd1;
                end else begin
                    // Rewind so the partial capture gets overwritten.
                    pkt_drop_d = 1'b1;
                    addr_d     = pkt_base_q;
                end
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        pipe_d = (pipe_q << 1) | PIPE_LAT'(w_wr_in);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= C_IDLE;
            word_cnt_q  <= '0;
            bad_q       <= 1'b0;
            bytes_q     <= '0;
            drain_cnt_q <= '0;
            pipe_q      <= '0;
            addr_q      <= '0;
            pkt_base_q  <= '0;
            pkt_bytes_q <= '0;
            pkt_done_q  <= 1'b0;
            pkt_drop_q  <= 1'b0;
            mac_hits_q  <= '0;
            ip_hits_q   <= '0;
            port_hits_q <= '0;
            url_hits_q  <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            bad_q       <= bad_d;
            bytes_q     <= bytes_d;
            drain_cnt_q <= drain_cnt_d;
            pipe_q      <= pipe_d;
            addr_q      <= addr_d;
            pkt_base_q  <= pkt_base_d;
            pkt_bytes_q <= pkt_bytes_d;
            pkt_done_q  <= pkt_done_d;
            pkt_drop_q  <= pkt_drop_d;
            mac_hits_q  <= mac_hits_d;
            ip_hits_q   <= ip_hits_d;
            port_hits_q <= port_hits_d;
            url_hits_q  <= url_hits_d;
        end
    end

    assign write_enable = pipe_q[PIPE_LAT-1];
    assign addr_out     = addr_q;
    assign pkt_base     = pkt_base_q;
    assign pkt_bytes    = pkt_bytes_q;
    assign pkt_done     = pkt_done_q;
    assign pkt_drop     = pkt_drop_q;
    assign mac_hits     = mac_hits_q;
    assign ip_hits      = ip_hits_q;
    assign port_hits    = port_hits_q;
    assign url_hits     = url_hits_q;

endmodule
`default_nettype wire

// File: tb/tb_sniffer_rx_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sniffer_rx_controller
// Purpose  : Scoreboard bench for sniffer_rx_controller. Stimulus pushes the
//            expected writes and packet outcomes; a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_sniffer_rx_controller;

    localparam int          PIPE_LAT = 5;
    localparam logic [31:0] STEP     = 32'd4;
    localparam logic [31:0] LIMIT    = 32'h0000_0800;
    localparam int          MAXW     = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        update_done = 1'b0;
    logic        sop = 1'b0, eop = 1'b0, valid = 1'b0;
    logic [5:0]  error = 6'd0;
    logic [1:0]  empty = 2'd0;
    logic        mac_match = 1'b0, ip_match = 1'b0, port_match = 1'b0, url_match = 1'b0;
    logic        ready, shift_en, matcher_clear, write_enable, pkt_done, pkt_drop;
    logic [31:0] addr_out, pkt_base, mac_hits, ip_hits, port_hits, url_hits;
    logic [15:0] pkt_bytes;

    sniffer_rx_controller #(
        .PIPE_LAT(PIPE_LAT), .ADDR_STEP(STEP), .ADDR_LIMIT(LIMIT), .MAX_WORDS(MAXW)
    ) dut (
        .clk(clk), .rst(rst), .update_done(update_done), .sop(sop), .eop(eop),
        .valid(valid), .error(error), .empty(empty), .mac_match(mac_match),
        .ip_match(ip_match), .port_match(port_match), .url_match(url_match),
        .ready(ready), .shift_en(shift_en), .matcher_clear(matcher_clear),
        .write_enable(write_enable), .addr_out(addr_out), .pkt_base(pkt_base),
        .pkt_bytes(pkt_bytes), .pkt_done(pkt_done), .pkt_drop(pkt_drop),
        .mac_hits(mac_hits), .ip_hits(ip_hits), .port_hits(port_hits), .url_hits(url_hits)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [31:0] addr; } wr_t;
    typedef struct {
        bit          drop;
        logic [15:0] bytes;
        logic [31:0] base;
        logic [31:0] addr;
        logic [3:0][31:0] hits;
    } res_t;

    wr_t  wq[$];
    res_t rq[$];
    wr_t  mw;
    res_t mr;
    bit   mon_en = 1'b1;

    int checks = 0;
    int failures = 0;

    // Reference state: next capture address, hit counts (3=mac..0=url), last bytes.
    logic [31:0]      m_addr = 32'd0;
    logic [3:0][31:0] m_hits = '0;
    logic [15:0]      m_bytes = 16'd0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] next_addr(logic [31:0] a);
        logic [31:0] n;
        n = a + STEP;
        return (n == LIMIT) ? 32'd0 : n;
    endfunction

    // Monitor: every strobe and every outcome pulse must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (write_enable) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    mw = wq.pop_front();
                    check("write_cycle", 32'(cyc), 32'(mw.cyc));
                    check("write_addr", addr_out, mw.addr);
                end
            end
            if (pkt_done || pkt_drop) begin
                if (rq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mr = rq.pop_front();
                    check("pkt_done", 32'(pkt_done), 32'(!mr.drop));
                    check("pkt_drop", 32'(pkt_drop), 32'(mr.drop));
                    check("pkt_bytes", 32'(pkt_bytes), 32'(mr.bytes));
                    check("pkt_base", pkt_base, mr.base);
                    check("addr_after", addr_out, mr.addr);
                    check("mac_hits", mac_hits, mr.hits[3]);
                    check("ip_hits", ip_hits, mr.hits[2]);
                    check("port_hits", port_hits, mr.hits[1]);
                    check("url_hits", url_hits, mr.hits[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        valid = 1'b0; sop = 1'b0; eop = 1'b0; update_done = 1'b0;
        error = 6'($urandom_range(0, 63));
    endtask

    task automatic arm();
        tick(); idle_in(); update_done = 1'b1;
        #2;
        check("matcher_clear_on_arm", 32'(matcher_clear), 32'd1);
        check("ready_idle", 32'(ready), 32'd0);
    endtask

    // A start-of-packet offered while not armed must be refused.
    task automatic probe_idle();
        tick(); idle_in(); valid = 1'b1; sop = 1'b1; eop = 1'b1; error = 6'd0;
        #2;
        check("ready_before_arm", 32'(ready), 32'd0);
        check("shift_en_before_arm", 32'(shift_en), 32'd0);
        tick(); idle_in();
    endtask

    task automatic drive_word(bit s, bit e, logic [5:0] err, bit ud);
        tick();
        update_done = ud; valid = 1'b1; sop = s; eop = e; error = err;
        #2;
        check("ready_in_pkt", 32'(ready), 32'd1);
        check("shift_en", 32'(shift_en), 32'd1);
        if (ud) check("update_done_ignored", 32'(matcher_clear), 32'd0);
    endtask

    task automatic send_packet(int n, logic [1:0] emp, int err_at, logic [5:0] errv,
                               logic [3:0] flags, int gap_pct, int stall_at,
                               bit lead_junk, bit ud_mid);
        logic [31:0] base;
        bit          bad;
        bit          bad_now;
        logic [5:0]  err;
        res_t        r;
        int          k;
        base = m_addr;
        bad  = 1'b0;
        arm();
        {mac_match, ip_match, port_match, url_match} = flags;
        empty = emp;
        if (lead_junk) begin
            tick(); idle_in(); valid = 1'b1; error = 6'd0;
        end
        for (int i = 1; i <= n; i++) begin
            if (i == stall_at) begin
                repeat (3) begin tick(); idle_in(); end
            end
            while ($urandom_range(0, 99) < gap_pct) begin tick(); idle_in(); end
            err = (i == err_at) ? errv : 6'd0;
            drive_word(i == 1, i == n, err, ud_mid && (i == (n + 1) / 2) && (i > 1));
            bad_now = bad || (err != 6'd0) || (i > MAXW);
            if (!bad_now) begin
                wq.push_back('{cyc + PIPE_LAT, m_addr});
                m_addr = next_addr(m_addr);
            end
            bad = bad_now;
        end
        tick(); idle_in();
        r.drop = bad;
        r.base = base;
        if (bad) begin
            m_addr = base;
        end else begin
            for (int j = 0; j < 4; j++)
                if (flags[j] && m_hits[j] != 32'hFFFF_FFFF) m_hits[j] = m_hits[j] + 32'd1;
            m_bytes = 16'(n * 4 - int'(emp));
        end
        r.addr  = m_addr;
        r.bytes = m_bytes;
        r.hits  = m_hits;
        rq.push_back(r);
        k = 0;
        while (rq.size() != 0 && k < 40) begin tick(); k++; end
        if (rq.size() != 0) begin
            check("result_timeout", 32'd1, 32'd0);
            rq.delete();
        end
        check("writes_drained", 32'(wq.size()), 32'd0);
        wq.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_addr", addr_out, 32'd0);
        tick(); rst = 1'b0;
        probe_idle();

        // Clean 196-word packet, mac/ip/port hit
        send_packet(196, 2'd0, 0, 6'd0, 4'b1110, 0, 0, 1'b0, 1'b0);
        check("A_addr", addr_out, 32'h310);
        check("A_bytes", 32'(pkt_bytes), 32'd784);
        check("A_mac", mac_hits, 32'd1);
        check("A_url", url_hits, 32'd0);

        // 72 words, empty=1, url only, with a 3-cycle stall and ignored update_done
        send_packet(72, 2'd1, 0, 6'd0, 4'b0001, 0, 30, 1'b0, 1'b1);
        check("B_base", pkt_base, 32'h310);
        check("B_bytes", 32'(pkt_bytes), 32'd287);
        check("B_url", url_hits, 32'd1);
        check("B_ip", ip_hits, 32'd1);
        probe_idle();

        // Error on word 60 of 134, then an over-length packet
        send_packet(134, 2'd0, 60, 6'h3F, 4'b1111, 0, 0, 1'b0, 1'b0);
        check("C_rewind", addr_out, pkt_base);
        send_packet(513, 2'd0, 0, 6'd0, 4'b1111, 0, 0, 1'b0, 1'b0);
        check("D_port", port_hits, 32'd1);

        // Reset in the middle of a packet
        mon_en = 1'b0;
        arm();
        for (int i = 1; i <= 10; i++) drive_word(i == 1, 1'b0, 6'd0, 1'b0);
        tick(); idle_in(); rst = 1'b1;
        #2;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_we", 32'(write_enable), 32'd0);
        tick(); rst = 1'b0;
        #2;
        check("post_rst_ready", 32'(ready), 32'd0);
        check("post_rst_we", 32'(write_enable), 32'd0);
        check("post_rst_addr", addr_out, 32'd0);
        check("post_rst_hits", mac_hits | ip_hits | port_hits | url_hits, 32'd0);
        wq.delete(); rq.delete();
        m_addr = 32'd0; m_hits = '0; m_bytes = 16'd0;
        mon_en = 1'b1;
        probe_idle();

        // Randomized traffic (wraps the small capture buffer several times)
        for (int p = 0; p < 40; p++) begin
            int n;
            int ea;
            n  = $urandom_range(1, 60);
            ea = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n) : 0;
            send_packet(n, 2'($urandom_range(0, 3)), ea, 6'($urandom_range(1, 63)),
                        4'($urandom_range(0, 15)), 20, 0,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) probe_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
